// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between mem_stage and the data memory.
//   master (mem_stage): req, we, addr, wdata, be out; ack, rdata in
//   slave  (memory)   : the reverse
// ack may arrive in any cycle while req is high; rdata is valid in that cycle.
interface mem_stage_if #(parameter int XLEN = 32);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores on the dmem bus, extracts load data,
// stalls the front of the pipe while a transaction is outstanding and owns the
// MEM/WB register.
// Ports:
//   clk, reset         clock, async active-high reset
//   *M inputs          EX/MEM pipeline register fields, FlushM kill
//   StallM             combinational freeze of PC .. EX/MEM
//   dmem               data-memory bus (master side)
//   *W outputs         MEM/WB register to wb_stage, MisalignW fault pulse
//
// state | meaning
// IDLE  | no transaction; non-memory ops pass straight to MEM/WB
// BUSY  | request on the bus, waiting for ack
// DONE  | load data captured; EX/MEM advances, result enters MEM/WB
module mem_stage #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ValidM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] ImmExtM,
  input  logic [4:0]      RdM,
  input  logic [2:0]      funct3M,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic            FlushM,
  output logic            StallM,
  mem_stage_if.master     dmem,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] LoadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ImmExtW,
  output logic            MisalignW
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT           state, nextState;
  logic            memOp, isStore, badFunct, badAlign, fault, faultNow, issue;
  logic            killed, bubble;
  logic [1:0]      off, offQ;
  logic [2:0]      funct3Q;
  logic [3:0]      beD;
  logic [XLEN-1:0] wdataD, shifted, loadExt, loadDataQ;
  logic [7:0]      byteSel;
  logic [15:0]     halfSel;

  assign memOp   = ValidM & (MemReadM | MemWriteM);
  assign isStore = MemWriteM & !MemReadM;
  assign off     = ALUResultM[1:0];

  always_comb begin
    badFunct = 1'b0;
    badAlign = 1'b0;
    if (MemReadM)
      badFunct = !(funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      badFunct = !(funct3M inside {3'b000, 3'b001, 3'b010});
    case (funct3M[1:0])
      2'b01:   badAlign = off[0];
      2'b10:   badAlign = (off != 2'b00);
      default: badAlign = 1'b0;
    endcase
  end

  assign fault    = memOp & (badFunct | badAlign);
  assign faultNow = (state == IDLE) & fault;
  assign issue    = memOp & !fault & !FlushM;

  // Store lane steering; loads always read the full word.
  always_comb begin
    beD    = 4'b1111;
    wdataD = WriteDataM;
    if (isStore) begin
      case (funct3M[1:0])
        2'b00: begin
          beD    = 4'b0001 << off;
          wdataD = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          beD    = 4'b0011 << off;
          wdataD = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Extraction uses the size/offset latched at issue, not the live M fields.
  assign shifted = dmem.rdata >> {offQ, 3'b000};
  assign byteSel = shifted[7:0];
  assign halfSel = offQ[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

  always_comb begin
    case (funct3Q)
      3'b000:  loadExt = {{(XLEN-8){byteSel[7]}}, byteSel};
      3'b100:  loadExt = {{(XLEN-8){1'b0}}, byteSel};
      3'b001:  loadExt = {{(XLEN-16){halfSel[15]}}, halfSel};
      3'b101:  loadExt = {{(XLEN-16){1'b0}}, halfSel};
      default: loadExt = dmem.rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    StallM    = 1'b0;
    case (state)
      IDLE: if (issue) begin
        nextState = BUSY;
        StallM    = 1'b1;
      end
      BUSY: begin
        StallM = 1'b1;
        if (dmem.ack) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (reset) StallM = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.be    <= 4'b0000;
      dmem.addr  <= '0;
      dmem.wdata <= '0;
      funct3Q    <= 3'b000;
      offQ       <= 2'b00;
      loadDataQ  <= '0;
      killed     <= 1'b0;
    end else begin
      if (state == IDLE && issue) begin
        dmem.req   <= 1'b1;
        dmem.we    <= isStore;
        dmem.be    <= beD;
        dmem.addr  <= {ALUResultM[XLEN-1:2], 2'b00};
        dmem.wdata <= wdataD;
        funct3Q    <= funct3M;
        offQ       <= off;
      end
      if (state == BUSY && dmem.ack) begin
        dmem.req  <= 1'b0;
        loadDataQ <= loadExt;
      end
      // A flush cannot abort the bus cycle; remember it and drop the result.
      if (state == BUSY && FlushM) killed <= 1'b1;
      else if (state == DONE)      killed <= 1'b0;
    end
  end

  assign bubble = FlushM | StallM | !ValidM | faultNow | ((state == DONE) & killed);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ALUResultW <= '0;
      LoadDataW  <= '0;
      PCPlus4W   <= '0;
      ImmExtW    <= '0;
      MisalignW  <= 1'b0;
    end else begin
      MisalignW <= faultNow & !FlushM;
      if (bubble) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= 2'b00;
        RdW        <= 5'd0;
        ALUResultW <= '0;
        LoadDataW  <= '0;
        PCPlus4W   <= '0;
        ImmExtW    <= '0;
      end else begin
        RegWriteW  <= RegWriteM;
        ResultSrcW <= ResultSrcM;
        RdW        <= RdM;
        ALUResultW <= ALUResultM;
        LoadDataW  <= MemReadM ? loadDataQ : '0;
        PCPlus4W   <= PCPlus4M;
        ImmExtW    <= ImmExtM;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ValidM, MemReadM, MemWriteM, RegWriteM, FlushM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, ImmExtM;
  logic [4:0]  RdM;
  logic [2:0]  funct3M;
  logic [1:0]  ResultSrcM;
  logic        StallM;
  logic        RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, LoadDataW, PCPlus4W, ImmExtW;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(32)) dmem ();

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .ValidM(ValidM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM), .RdM(RdM),
    .funct3M(funct3M), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .FlushM(FlushM),
    .StallM(StallM), .dmem(dmem), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .ALUResultW(ALUResultW), .LoadDataW(LoadDataW), .PCPlus4W(PCPlus4W),
    .ImmExtW(ImmExtW), .MisalignW(MisalignW)
  );

  wire [135:0] wAct = {RegWriteW, ResultSrcW, RdW, ALUResultW, LoadDataW, PCPlus4W, ImmExtW};

  // Applies one instruction to EX/MEM (called #1 after a rising edge), acts as
  // the memory with waitN wait cycles, and checks against the reference model.
  // flushMode: 0 none, 1 FlushM with the instruction, 2 FlushM pulse in first BUSY cycle.
  task automatic do_op(input logic v, input logic rd, input logic wr, input logic regw,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdat, input int waitN, input int flushMode,
                       input logic [4:0] rdIdx, input logic [1:0] rs,
                       input logic [31:0] pc4, input logic [31:0] imm);
    int          size, off, stalls, reqs, expStalls, expReqs;
    logic        memop, legal, fault, issued, flushed, bub, stallNow, done;
    logic [3:0]  expBe;
    logic [31:0] expWd, expLd, raw, mask, expAddr;
    logic [135:0] wExp;
    logic [37:0] busExp, busAct;

    memop   = v && (rd || wr);
    legal   = rd ? (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) : (f3 <= 3'd2);
    size    = 1 << f3[1:0];
    off     = addr % 4;
    fault   = memop && (!legal || (addr % size) != 0);
    issued  = memop && !fault && flushMode != 1;
    flushed = (flushMode == 1) || (flushMode == 2 && issued);
    bub     = !v || flushed || fault;
    expAddr = addr & 32'hFFFF_FFFC;
    expBe   = 4'hF;
    expWd   = wd;
    if (!rd && size <= 4) begin
      expBe = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) expWd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    raw  = rdat >> (8 * off);
    mask = (size >= 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
    expLd = (size >= 4) ? rdat : (raw & mask);
    if (!f3[2] && size < 4 && expLd[8*size-1]) expLd = expLd | ~mask;
    if (!rd) expLd = 32'd0;
    wExp = bub ? 136'd0 : {regw, rs, rdIdx, addr, expLd, pc4, imm};
    busExp = {!rd, expBe, expAddr[31:0], 1'b1};
    expStalls = issued ? waitN + 2 : 0;
    expReqs   = issued ? waitN + 1 : 0;

    ValidM = v; MemReadM = rd; MemWriteM = wr; RegWriteM = regw; funct3M = f3;
    ALUResultM = addr; WriteDataM = wd; RdM = rdIdx; ResultSrcM = rs;
    PCPlus4M = pc4; ImmExtM = imm; FlushM = (flushMode == 1);
    stalls = 0; reqs = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (StallM) stalls++;
      if (dmem.req) begin
        reqs++;
        if (reqs == 1 && flushMode == 2) FlushM = 1'b1;
        busAct = {dmem.we, dmem.be, dmem.addr, 1'b1};
        checks++;
        if (busAct !== busExp) $display("FAIL bus_fields: got %h want %h", busAct, busExp);
        else passed++;
        if (!rd) begin
          checks++;
          if (dmem.wdata !== expWd) $display("FAIL store_wdata: got %h want %h", dmem.wdata, expWd);
          else passed++;
        end
        dmem.ack   = (reqs == waitN + 1);
        dmem.rdata = dmem.ack ? rdat : $urandom;
      end
      stallNow = StallM;
      @(posedge clk); #1;
      dmem.ack = 1'b0;
      FlushM   = 1'b0;
      if (!stallNow) done = 1;
    end
    checks++;
    if (!done) $display("FAIL op_timeout: got stall still high want release within 40 cycles");
    else passed++;
    checks++;
    if (wAct !== wExp) $display("FAIL w_result: got %h want %h", wAct, wExp);
    else passed++;
    checks++;
    if (MisalignW !== (fault && flushMode != 1))
      $display("FAIL misalign: got %b want %b", MisalignW, fault && flushMode != 1);
    else passed++;
    checks++;
    if (stalls !== expStalls) $display("FAIL stall_cycles: got %0d want %0d", stalls, expStalls);
    else passed++;
    checks++;
    if (reqs !== expReqs) $display("FAIL req_cycles: got %0d want %0d", reqs, expReqs);
    else passed++;
    // EX/MEM advances to a bubble: MEM/WB must follow with a bubble, no fault, no request.
    ValidM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({wAct, MisalignW, dmem.req, StallM} !== 139'd0)
      $display("FAIL trailing_bubble: got %h want 0", {wAct, MisalignW, dmem.req, StallM});
    else passed++;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({wAct, MisalignW, dmem.req, dmem.we, dmem.be, StallM} !== 143'd0)
      $display("FAIL reset_state: got %h want 0", {wAct, MisalignW, dmem.req, dmem.we, dmem.be, StallM});
    else passed++;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    ValidM = 1'b1; RegWriteM = 1'b1; RdM = 5'd9; ALUResultM = 32'h1234_5678; PCPlus4M = 32'h44;
    @(posedge clk); #1;
    checks++;
    if (RegWriteW !== 1'b1 || RdW !== 5'd9)
      $display("FAIL pre_reset_capture: got %b/%0d want 1/9", RegWriteW, RdW);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({wAct, MisalignW} !== 137'd0) $display("FAIL async_reset_w: got %h want 0", {wAct, MisalignW});
    else passed++;
    ValidM = 1'b0; RegWriteM = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    do_op(1, 0, 0, 1, 3'd0, 32'h10, 32'h0, 32'h0, 0, 0, 5'd5, 2'b00, 32'h104, 32'h7);
  endtask

  task automatic test_load_byte();
    do_op(1, 1, 0, 1, 3'b000, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0, 5'd6, 2'b01, 32'h108, 32'h3);
  endtask

  task automatic test_store_half();
    do_op(1, 0, 1, 0, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 3, 0, 5'd0, 2'b00, 32'h10C, 32'h2);
  endtask

  task automatic test_misalign();
    do_op(1, 1, 0, 1, 3'b010, 32'h3001, 32'h0, 32'hDEAD_BEEF, 0, 0, 5'd7, 2'b01, 32'h110, 32'h1);
  endtask

  task automatic test_flush_busy();
    do_op(1, 1, 0, 1, 3'b101, 32'h4002, 32'h0, 32'h8001_0000, 2, 2, 5'd8, 2'b01, 32'h114, 32'h2);
    do_op(1, 1, 0, 1, 3'b101, 32'h4002, 32'h0, 32'h8001_0000, 1, 0, 5'd8, 2'b01, 32'h118, 32'h2);
  endtask

  task automatic test_reset_busy();
    logic seen;
    seen = 0;
    ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; RegWriteM = 1'b1;
    funct3M = 3'b101; ALUResultM = 32'h4002; RdM = 5'd3; FlushM = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      if (dmem.req) seen = 1;
    end
    checks++;
    if (!seen) $display("FAIL reach_busy: got no request want request within 5 cycles");
    else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if ({dmem.req, dmem.we, dmem.be, StallM, wAct, MisalignW} !== 143'd0)
      $display("FAIL reset_in_busy: got %h want 0", {dmem.req, dmem.we, dmem.be, StallM, wAct, MisalignW});
    else passed++;
    ValidM = 1'b0; MemReadM = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    dmem.ack = 1'b1; dmem.rdata = $urandom;
    @(posedge clk); #1;
    dmem.ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({StallM, dmem.req} !== 2'b00) $display("FAIL stray_ack: got %b want 00", {StallM, dmem.req});
    else passed++;
    @(posedge clk); #1;
    do_op(1, 1, 0, 1, 3'b010, 32'h5004, 32'h0, 32'hCAFE_F00D, 1, 0, 5'd4, 2'b01, 32'h200, 32'h4);
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind, fm;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (kind == 2) f3 = 3'($urandom_range(0, 2));
        else if (f3 == 3'd3 || f3 >= 3'd6) f3 = 3'b100;
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      fm = $urandom_range(0, 9);
      fm = (fm == 0) ? 1 : (fm <= 2) ? 2 : 0;
      do_op($urandom_range(0, 9) != 0, kind == 1, kind == 2, 1'($urandom),
            f3, a, $urandom, $urandom, $urandom_range(0, 3), fm,
            5'($urandom), 2'($urandom), $urandom, $urandom);
    end
  endtask

  initial begin
    reset = 1'b1;
    ValidM = 0; MemReadM = 0; MemWriteM = 0; RegWriteM = 0; FlushM = 0;
    ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0; ImmExtM = 0; RdM = 0;
    funct3M = 0; ResultSrcM = 0;
    dmem.ack = 1'b0; dmem.rdata = 32'd0;
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_flush_busy();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
RV32I memory stage. It sits between the EX/MEM pipeline register and wb_stage, and it owns the MEM/WB register.
- Issues load/store transactions on a req/ack data-memory bus and generates byte enables.
- Extracts and sign/zero-extends load data.
- Stalls the front of the pipe while a transaction is outstanding.
- Delivers registered results (ALU result, load data, PC+4, immediate, Rd, controls) to writeback.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
ValidM  in  1  EX/MEM entry holds a real instruction.
ALUResultM  in  32  ALU result / effective address.
WriteDataM  in  32  store data (rs2).
PCPlus4M  in  32  PC+4 of the instruction.
ImmExtM  in  32  extended immediate.
RdM  in  5  destination register.
funct3M  in  3  load/store size and sign.
MemReadM  in  1  load.
MemWriteM  in  1  store.
RegWriteM  in  1  register write enable.
ResultSrcM  in  2  writeback mux select.
FlushM  in  1  kill the instruction in MEM.
StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational).
dmem_req  out  1  request valid (registered).
dmem_we  out  1  write request.
dmem_addr  out  32  word-aligned address; bits [1:0] are 0.
dmem_wdata  out  32  lane-aligned store data.
dmem_be  out  4  byte enables.
dmem_ack  in  1  request accepted/completed; dmem_rdata valid in the same cycle.
dmem_rdata  in  32  read word.
RegWriteW  out  1  to wb_stage.
ResultSrcW  out  2  to wb_stage.
RdW  out  5  to wb_stage.
ALUResultW  out  32  to wb_stage.
LoadDataW  out  32  extended load data.
PCPlus4W  out  32  to wb_stage.
ImmExtW  out  32  to wb_stage.
MisalignW  out  1  registered one-cycle fault flag for the trap logic.

Behaviour:
- MemOp = ValidM & (MemReadM | MemWriteM).
- Alignment fault: lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]≠0, or funct3 not in {000,001,010,100,101} for a load or {000,001,010} for a store.
- Store lanes (off = addr[1:0]):
  - sb: be = 0001<<off, wdata = byte replicated ×4.
  - sh: be = 0011<<off, wdata = halfword replicated ×2.
  - sw: be = 1111.
  - Loads: be = 1111, we = 0.
- Load extraction (from the word captured on ack):
  - lb/lbu: byte at off, sign/zero extended.
  - lh/lhu: halfword at off[1], sign/zero extended.
  - lw: full word.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - MemOp & !fault & !FlushM: latch addr/we/be/wdata, go to BUSY, StallM=1.
    - Otherwise StallM=0.
  - BUSY:
    - dmem_req=1; addr/we/be/wdata held stable until ack.
    - StallM=1.
    - On dmem_ack: capture extended load data, go to DONE.
  - DONE: StallM=0 so EX/MEM advances at this edge; go to IDLE.
- Minimum memory-op occupancy is 3 cycles (IDLE, BUSY with ack in the first cycle, DONE). Each extra wait cycle adds one.
- dmem_req is high only in BUSY and drops the cycle after ack.
- MEM/WB register, each edge:
  - FlushM, StallM=1, or !ValidM: load a bubble (RegWriteW=0, all other W outputs 0, MisalignW=0).
  - Fault (and not flushed): bubble with MisalignW=1 for one cycle; no bus request.
  - Otherwise: capture the M-side fields and LoadDataW (0 for non-loads).
- Flush during BUSY: the transaction cannot be aborted. Set the kill flag and keep StallM=1 until ack. At DONE, insert a bubble instead of the result; the kill flag clears on return to IDLE.
- Reset (asynchronous, any state) forces:
  - FSM state to IDLE; kill flag to 0.
  - dmem_req=0, dmem_we=0, dmem_be=0.
  - All W outputs to 0, MisalignW=0.
  - StallM to 0, since it is a function of state.
  - A reset mid-transaction drops the request; a late ack in IDLE is ignored.

Test Plan:
1. Non-memory add (RegWriteM=1, RdM=5, ALUResultM=0x10) -> next edge RegWriteW=1, RdW=5, ALUResultW=0x10; StallM never asserts.
2. lb at 0x1003, rdata=0x80FF_FF_FF, ack in the first BUSY cycle -> StallM high for 2 cycles, dmem_addr=0x1000, be=1111; LoadDataW=0xFFFFFF80.
3. sh at 0x2002, WriteDataM=0x0000ABCD, ack after 3 wait cycles -> be=1100, wdata=0xABCDABCD, dmem_req high for 4 cycles, StallM for 5; then a bubble followed by RegWriteW=0.
4. lw at 0x3001 -> no dmem_req, StallM=0, MisalignW=1 for one cycle, RegWriteW=0.
5. lhu at 0x4002 with FlushM pulsed in BUSY, rdata=0x8001_0000 -> stall held until ack, RegWriteW stays 0; lhu at 0x4002 unflushed -> LoadDataW=0x00008001.
6. Assert reset in BUSY -> dmem_req=0, StallM=0 and all W outputs 0 immediately; a subsequent stray ack leaves the FSM in IDLE.
